// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with bubble, hold, flush and multi-cycle context circulation.
// Optional performance counters are built only when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_reg #(
    parameter int                DATA_W   = 128,
    parameter int                CTX_W    = 66,
    parameter int                STALL_W  = 6,
    parameter int                STAGE    = 3,
    parameter logic [DATA_W-1:0] NOP_DATA = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [CTX_W-1:0]   ctx_i,
    output logic               out_valid,
    output logic [DATA_W-1:0]  out_data,
    output logic [CTX_W-1:0]   ctx_o,
    output logic [1:0]         last_act,
    output logic [31:0]        bubble_cnt,
    output logic [31:0]        hold_cnt
);

    typedef enum logic [1:0] {
        ACT_RESET   = 2'd0,
        ACT_ADVANCE = 2'd1,
        ACT_BUBBLE  = 2'd2,
        ACT_HOLD    = 2'd3
    } act_t;

    // Valid semantics: out_valid=1 marks out_data as a real instruction for the
    // downstream stage; there is no ready, back-pressure arrives only through stall.
    logic stall_up;
    logic stall_dn;
    act_t next_act;
    logic unused_stall;

    assign stall_up     = stall[STAGE];
    assign stall_dn     = stall[STAGE+1];
    assign unused_stall = ^stall;

    // An unstalled upstream always advances, even if downstream claims a stall.
    always_comb begin
        next_act = ACT_HOLD;
        if (rst || flush)
            next_act = ACT_RESET;
        else if (stall_up && !stall_dn)
            next_act = ACT_BUBBLE;
        else if (!stall_up)
            next_act = ACT_ADVANCE;
    end

    always_ff @(posedge clk) begin
        last_act <= next_act;
        case (next_act)
            ACT_RESET: begin
                out_valid <= 1'b0;
                out_data  <= NOP_DATA;
                ctx_o     <= '0;
            end
            ACT_BUBBLE: begin
                out_valid <= 1'b0;
                out_data  <= NOP_DATA;
                ctx_o     <= ctx_i;
            end
            ACT_ADVANCE: begin
                out_valid <= in_valid;
                out_data  <= in_valid ? in_data : NOP_DATA;
                ctx_o     <= '0;
            end
            default: begin
                ctx_o <= ctx_i;
            end
        endcase
    end

`ifdef PIPE_STAGE_PERF_EN
    // Flush leaves the counters alone; only reset clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt <= 32'd0;
            hold_cnt   <= 32'd0;
        end else begin
            if (next_act == ACT_BUBBLE)
                bubble_cnt <= bubble_cnt + 32'd1;
            if (next_act == ACT_HOLD)
                hold_cnt <= hold_cnt + 32'd1;
        end
    end
`else
    assign bubble_cnt = 32'h0;
    assign hold_cnt   = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed test-plan steps followed by random traffic,
// checked against a rule-level reference model through an expected queue.
module tb_pipe_stage_reg;

    localparam int DATA_W  = 128;
    localparam int CTX_W   = 66;
    localparam int STALL_W = 6;
    localparam int STAGE   = 3;
    localparam int EW      = 1 + DATA_W + CTX_W + 2 + 32 + 32;
    localparam logic [DATA_W-1:0] NOP = '0;

    logic               clk;
    logic               rst;
    logic [STALL_W-1:0] stall;
    logic               flush;
    logic               in_valid;
    logic [DATA_W-1:0]  in_data;
    logic [CTX_W-1:0]   ctx_i;
    logic               out_valid;
    logic [DATA_W-1:0]  out_data;
    logic [CTX_W-1:0]   ctx_o;
    logic [1:0]         last_act;
    logic [31:0]        bubble_cnt;
    logic [31:0]        hold_cnt;

    int total = 0;
    int bad   = 0;

    pipe_stage_reg #(
        .DATA_W(DATA_W), .CTX_W(CTX_W), .STALL_W(STALL_W), .STAGE(STAGE), .NOP_DATA(NOP)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .ctx_i(ctx_i),
        .out_valid(out_valid), .out_data(out_data), .ctx_o(ctx_o),
        .last_act(last_act), .bubble_cnt(bubble_cnt), .hold_cnt(hold_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // CTRL never stalls downstream while upstream runs; flag it if stimulus ever does.
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(!stall[STAGE] && stall[STAGE+1]))
            else begin
                bad++;
                $error("FAIL illegal_stall observed=%b required=no (0,1) pair", stall);
            end
        end
    end

    // reference model state
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic [CTX_W-1:0]  m_ctx;
    logic [1:0]        m_act;
    logic [31:0]       m_bub;
    logic [31:0]       m_hold;

    logic [EW-1:0] exp_q[$];

    task automatic model_edge();
        logic [31:0] eb;
        logic [31:0] eh;
        if (rst) begin
            m_valid = 1'b0; m_data = NOP; m_ctx = '0; m_act = 2'd0; m_bub = 0; m_hold = 0;
        end else if (flush) begin
            m_valid = 1'b0; m_data = NOP; m_ctx = '0; m_act = 2'd0;
        end else if (stall[STAGE] && !stall[STAGE+1]) begin
            m_valid = 1'b0; m_data = NOP; m_ctx = ctx_i; m_act = 2'd2; m_bub = m_bub + 1;
        end else if (!stall[STAGE]) begin
            m_valid = in_valid; m_data = in_valid ? in_data : NOP; m_ctx = '0; m_act = 2'd1;
        end else begin
            m_ctx = ctx_i; m_act = 2'd3; m_hold = m_hold + 1;
        end
`ifdef PIPE_STAGE_PERF_EN
        eb = m_bub; eh = m_hold;
`else
        eb = 32'h0; eh = 32'h0;
`endif
        exp_q.push_back({m_valid, m_data, m_ctx, m_act, eb, eh});
    endtask

    // scoreboard
    task automatic check_outputs();
        logic [EW-1:0]     e;
        logic              e_valid;
        logic [DATA_W-1:0] e_data;
        logic [CTX_W-1:0]  e_ctx;
        logic [1:0]        e_act;
        logic [31:0]       e_bub;
        logic [31:0]       e_hold;
        e = exp_q.pop_front();
        {e_valid, e_data, e_ctx, e_act, e_bub, e_hold} = e;
        total++;
        assert (out_valid === e_valid) else begin
            bad++; $error("FAIL out_valid observed=%b expected=%b", out_valid, e_valid);
        end
        total++;
        assert (out_data === e_data) else begin
            bad++; $error("FAIL out_data observed=%h expected=%h", out_data, e_data);
        end
        total++;
        assert (ctx_o === e_ctx) else begin
            bad++; $error("FAIL ctx_o observed=%h expected=%h", ctx_o, e_ctx);
        end
        total++;
        assert (last_act === e_act) else begin
            bad++; $error("FAIL last_act observed=%0d expected=%0d", last_act, e_act);
        end
        total++;
        assert (bubble_cnt === e_bub) else begin
            bad++; $error("FAIL bubble_cnt observed=%0d expected=%0d", bubble_cnt, e_bub);
        end
        total++;
        assert (hold_cnt === e_hold) else begin
            bad++; $error("FAIL hold_cnt observed=%0d expected=%0d", hold_cnt, e_hold);
        end
    endtask

    // driver tasks
    task automatic drive(input logic r, input logic f, input logic [STALL_W-1:0] s,
                         input logic v, input logic [DATA_W-1:0] d, input logic [CTX_W-1:0] c);
        rst = r; flush = f; stall = s; in_valid = v; in_data = d; ctx_i = c;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic check_data(input string tag, input logic [DATA_W-1:0] req);
        total++;
        assert (out_data === req) else begin
            bad++; $error("FAIL %s observed=%h required=%h", tag, out_data, req);
        end
    endtask

    initial begin
        logic [STALL_W-1:0] s;
        int unsigned        sel;
        drive(1'b1, 1'b0, 6'b000000, 1'b1, 128'hDEAD, '0);
        #2;
        // reset held for two cycles with a live payload on the input
        step(); step();
        check_data("reset_data", 128'h0);
        // advance
        drive(1'b0, 1'b0, 6'b000000, 1'b1, 128'h1234, '0); step();
        check_data("advance_1234", 128'h1234);
        drive(1'b0, 1'b0, 6'b000000, 1'b1, 128'h5678, '0); step();
        check_data("advance_5678", 128'h5678);
        // bubble carrying context, then advance clears it
        drive(1'b0, 1'b0, 6'b001111, 1'b1, 128'h9999, 66'h2_0000_0001_0000_0002); step();
        drive(1'b0, 1'b0, 6'b000000, 1'b0, 128'h7777, 66'h1_1111_1111_1111_1111); step();
        // hold
        drive(1'b0, 1'b0, 6'b000000, 1'b1, 128'hABCD, '0); step();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 6'b011111, 1'b1, 128'h4444 + 128'(i), 66'(i + 5)); step();
        end
        check_data("hold_abcd", 128'hABCD);
        // flush over a hold
        drive(1'b0, 1'b1, 6'b011111, 1'b1, 128'h5555, 66'h3); step();
        check_data("flush_data", 128'h0);
        // reset in the middle of a hold with context in flight
        drive(1'b0, 1'b0, 6'b000000, 1'b1, 128'hBEEF, '0); step();
        drive(1'b0, 1'b0, 6'b011111, 1'b1, 128'h1, 66'h2_AAAA_BBBB_CCCC_DDDD); step();
        drive(1'b1, 1'b1, 6'b011111, 1'b1, 128'h2, 66'h1_2345); step();
        // random traffic over the three legal stall pairs
        for (int n = 0; n < 600; n++) begin
            s = 6'($urandom);
            sel = $urandom_range(0, 2);
            s[STAGE]   = (sel != 0);
            s[STAGE+1] = (sel == 2);
            drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 19) == 0), s,
                  1'($urandom), {$urandom, $urandom, $urandom, $urandom},
                  {2'($urandom), $urandom, $urandom});
            step();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
